// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and constants for the BCD timer controller.
//   state_e     - controller state (idle / run / pause / done)
//   bcd_digit_t - one BCD digit
//   bcd_sat()   - clamps an out-of-range nibble to 9
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// bcd_timer_ctrl_if: command / status bundle between button logic and the timer.
//   master: drives start, stop, clear, load, up, preset; observes digits, running, done, wrap
//   slave : the timer controller side
interface bcd_timer_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  load;
  logic                  up;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   digits;
  logic                  running;
  logic                  done;
  logic                  wrap;

  modport master (
    output start, stop, clear, load, up, preset,
    input  digits, running, done, wrap
  );

  modport slave (
    input  start, stop, clear, load, up, preset,
    output digits, running, done, wrap
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one registered BCD digit with up/down step, load and clear.
//   clk, rst_n  : clock, synchronous active-low reset
//   inc, dec    : step enables (inc has priority if both are set)
//   ld, ld_val  : load ld_val (clamped to 9)
//   clr         : zero the digit (highest priority)
//   value       : current digit
//   carry       : inc while at 9, feeds the next digit's inc
//   borrow      : dec while at 0, feeds the next digit's dec
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       clr,
  output bcd_digit_t value,
  output logic       carry,
  output logic       borrow
);

  bcd_digit_t value_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= BCD_ZERO;
    end else if (clr) begin
      value_q <= BCD_ZERO;
    end else if (ld) begin
      value_q <= bcd_sat(ld_val);
    end else if (inc) begin
      value_q <= (value_q >= BCD_MAX) ? BCD_ZERO : value_q + 4'd1;
    end else if (dec) begin
      value_q <= (value_q == BCD_ZERO) ? BCD_MAX : value_q - 4'd1;
    end
  end

  assign value  = value_q;
  assign carry  = inc & (value_q == BCD_MAX);
  assign borrow = dec & (value_q == BCD_ZERO);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: N-digit BCD timer/stopwatch sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bcd_timer_ctrl_if.slave (commands in, digits/running/done/wrap out)
// Parameters: DIGITS (1..8), PRESCALE (>=2 clk cycles per count tick).
// Build option: define AUTO_RELOAD_EN to reload the last loaded preset when a
// countdown reaches zero instead of stopping in the done state.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_timer_ctrl_if.slave  bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, done_q, done_d, wrap_q, wrap_d;

  logic          inc_en, dec_en, ld_en, clr_en;
  logic [W-1:0]  ld_vals, value_bus;
  logic [DIGITS-1:0] inc_in, dec_in, carry, borrow, nine_vec;
  logic          tick, all_zero, at_one, all_nine;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0]  shadow_q, shadow_d, preset_sat;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_t cell_value;

    if (k == 0) begin : g_lsd
      assign inc_in[k] = inc_en;
      assign dec_in[k] = dec_en;
    end else begin : g_chain
      assign inc_in[k] = carry[k-1];
      assign dec_in[k] = borrow[k-1];
    end

    bcd_digit_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc_in[k]),
      .dec    (dec_in[k]),
      .ld     (ld_en),
      .ld_val (ld_vals[4*k +: 4]),
      .clr    (clr_en),
      .value  (cell_value),
      .carry  (carry[k]),
      .borrow (borrow[k])
    );

    assign value_bus[4*k +: 4] = cell_value;
    assign nine_vec[k]         = (cell_value == BCD_MAX);
`ifdef AUTO_RELOAD_EN
    assign preset_sat[4*k +: 4] = bcd_sat(bus.preset[4*k +: 4]);
`endif
  end

  // The chain end only matters for detecting all-9s / all-0s, which is done
  // directly on the digit values to keep the next-state logic loop-free.
  logic unused_chain;
  assign unused_chain = carry[DIGITS-1] ^ borrow[DIGITS-1];

  assign tick     = (state_q == StRun) && (presc_q == PrescLast);
  assign all_zero = (value_bus == '0);
  assign at_one   = (value_bus == W'(1));
  assign all_nine = &nine_vec;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    inc_en  = 1'b0;
    dec_en  = 1'b0;
    ld_en   = 1'b0;
    clr_en  = 1'b0;
    ld_vals = bus.preset;
`ifdef AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif
    if (bus.clear) begin
      clr_en  = 1'b1;
      state_d = StIdle;
      presc_d = '0;
`ifdef AUTO_RELOAD_EN
      shadow_d = '0;
`endif
    end else if (bus.load) begin
      ld_en   = 1'b1;
      state_d = StIdle;
      presc_d = '0;
`ifdef AUTO_RELOAD_EN
      shadow_d = preset_sat;
`endif
    end else if (bus.stop) begin
      // Stop outranks start even when it is ignored; prescaler is held.
      if (state_q == StRun) state_d = StPause;
    end else if (bus.start && (state_q != StRun)) begin
      if (state_q != StDone) state_d = StRun;
    end else if (state_q == StRun) begin
      if (!tick) begin
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d = '0;
        if (bus.up) begin
          inc_en = 1'b1;
          wrap_d = all_nine;
        end else if (all_zero || at_one) begin
          done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          ld_en   = 1'b1;
          ld_vals = shadow_q;
`else
          state_d = StDone;
          dec_en  = ~all_zero;
`endif
        end else begin
          dec_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef AUTO_RELOAD_EN
      shadow_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= (state_d == StRun);
      done_q    <= done_d;
      wrap_q    <= wrap_d;
`ifdef AUTO_RELOAD_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  assign bus.digits  = value_bus;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: table-driven scoreboard bench for bcd_timer_ctrl
// (DIGITS=4, PRESCALE=4, default build).
module tb_bcd_timer_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 4;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] CLR  = 4'b1000;
  localparam logic [3:0] LD   = 4'b0100;
  localparam logic [3:0] STP  = 4'b0010;
  localparam logic [3:0] STA  = 4'b0001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus_if ();

  bcd_timer_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic        up;
    logic [15:0] preset;
    int          cyc;
    logic [15:0] e_dig;
    logic        e_run;
    logic        e_done;
    logic        e_wrap;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] dig;
    logic        run;
    logic        done;
    logic        wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] cmd, input logic up, input logic [15:0] preset,
                              input int cyc, input logic [15:0] dig, input logic run,
                              input logic done, input logic wrap);
    vec_t v;
    v.cmd = cmd; v.up = up; v.preset = preset; v.cyc = cyc;
    v.e_dig = dig; v.e_run = run; v.e_done = done; v.e_wrap = wrap;
    return v;
  endfunction

  task automatic set_cmd(input logic [3:0] cmd);
    bus_if.clear = cmd[3];
    bus_if.load  = cmd[2];
    bus_if.stop  = cmd[1];
    bus_if.start = cmd[0];
  endtask

  // Drive one command cycle at a negedge, then idle until the sample point.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    set_cmd(v.cmd);
    bus_if.up     = v.up;
    bus_if.preset = v.preset;
    e.idx = idx; e.dig = v.e_dig; e.run = v.e_run; e.done = v.e_done; e.wrap = v.e_wrap;
    sb.push_back(e);
    @(negedge clk);
    set_cmd(NONE);
    repeat (v.cyc - 1) @(negedge clk);
    e = sb.pop_front();
    check("digits",  e.idx, bus_if.digits, e.dig);
    check("running", e.idx, {15'b0, bus_if.running}, {15'b0, e.run});
    check("done",    e.idx, {15'b0, bus_if.done},    {15'b0, e.done});
    check("wrap",    e.idx, {15'b0, bus_if.wrap},    {15'b0, e.wrap});
  endtask

  task automatic pulse_cmd(input logic [3:0] cmd, input logic up, input logic [15:0] preset);
    set_cmd(cmd);
    bus_if.up     = up;
    bus_if.preset = preset;
    @(negedge clk);
    set_cmd(NONE);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    set_cmd(LD | STA);
    bus_if.up     = 1'b1;
    bus_if.preset = 16'h9999;

    // Reset with commands asserted: they must be ignored.
    repeat (2) @(negedge clk);
    check("rst_digits",  0, bus_if.digits, 16'h0000);
    check("rst_running", 0, {15'b0, bus_if.running}, 16'h0);
    check("rst_done",    0, {15'b0, bus_if.done}, 16'h0);
    check("rst_wrap",    0, {15'b0, bus_if.wrap}, 16'h0);
    set_cmd(NONE);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_digits",  0, bus_if.digits, 16'h0000);
    check("post_rst_running", 0, {15'b0, bus_if.running}, 16'h0);

    //            cmd          up    preset    cyc dig       run   done  wrap
    // up-count wrap
    tbl.push_back(mk(LD,        1'b1, 16'h9998, 1, 16'h9998, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 3, 16'h9998, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b1, 16'h0000, 2, 16'h9999, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b1, 16'h0000, 4, 16'h0000, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(NONE,      1'b1, 16'h0000, 1, 16'h0000, 1'b1, 1'b0, 1'b0));
    // countdown to done, start ignored in done
    tbl.push_back(mk(LD,        1'b0, 16'h0003, 1, 16'h0003, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b0, 16'h0000, 5, 16'h0002, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 4, 16'h0001, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 4, 16'h0000, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b0, 16'h0000, 5, 16'h0000, 1'b0, 1'b0, 1'b0));
    // borrow ripple, pause holds the partial period
    tbl.push_back(mk(LD,        1'b0, 16'h1000, 1, 16'h1000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b0, 16'h0000, 5, 16'h0999, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 2, 16'h0999, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(STP,       1'b0, 16'h0000, 5, 16'h0999, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b0, 16'h0000, 1, 16'h0999, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 1, 16'h0999, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 1, 16'h0998, 1'b1, 1'b0, 1'b0));
    // priority and preset coercion
    tbl.push_back(mk(CLR|LD|STP|STA, 1'b0, 16'h5555, 1, 16'h0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(LD,        1'b0, 16'h2C3A, 1, 16'h2939, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(LD|STP|STA, 1'b1, 16'h0042, 1, 16'h0042, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 1, 16'h0042, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(STP|STA,   1'b1, 16'h0000, 1, 16'h0042, 1'b0, 1'b0, 1'b0));
    // start in RUN on a tick lets the tick through; stop on a tick discards it
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 4, 16'h0042, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 1, 16'h0043, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b1, 16'h0000, 3, 16'h0043, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(STP,       1'b1, 16'h0000, 1, 16'h0043, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 1, 16'h0043, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b1, 16'h0000, 1, 16'h0044, 1'b1, 1'b0, 1'b0));
    // countdown from zero finishes immediately without wrapping
    tbl.push_back(mk(CLR,       1'b0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b0, 16'h0000, 5, 16'h0000, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, 1'b0));
    // direction only sampled on the tick cycle
    tbl.push_back(mk(LD,        1'b1, 16'h0500, 1, 16'h0500, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(STA,       1'b1, 16'h0000, 3, 16'h0500, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NONE,      1'b0, 16'h0000, 2, 16'h0499, 1'b1, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) run_vec(i + 1, tbl[i]);

    // done is a single-cycle pulse
    pulse_cmd(LD, 1'b0, 16'h0001);
    pulse_cmd(STA, 1'b0, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.done) cnt++;
    end
    check("done_pulse_count", 100, 16'(cnt), 16'd1);
    check("done_final_digits", 100, bus_if.digits, 16'h0000);
    check("done_final_running", 100, {15'b0, bus_if.running}, 16'h0);

    // wrap is a single-cycle pulse and counting continues
    pulse_cmd(LD, 1'b1, 16'h9999);
    pulse_cmd(STA, 1'b1, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.wrap) cnt++;
    end
    check("wrap_pulse_count", 101, 16'(cnt), 16'd1);
    check("wrap_final_digits", 101, bus_if.digits, 16'h0002);
    check("wrap_final_running", 101, {15'b0, bus_if.running}, 16'h1);

    // reset while running
    rst_n = 1'b0;
    set_cmd(STA);
    @(negedge clk);
    check("midrun_rst_digits", 102, bus_if.digits, 16'h0000);
    check("midrun_rst_running", 102, {15'b0, bus_if.running}, 16'h0);
    set_cmd(NONE);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
